// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 7-segment bus: debounces each common, decodes digits, rebuilds the tens/ones value.
// Optional macro SEG_HEX_EN: additionally accept hex glyphs A,b,C,d,E,F as values 10..15.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   com_in,
  output logic [4*NUM_DIGITS-1:0] digit_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic [6:0]              bin_value,
  output logic                    bin_valid,
  output logic                    update
);

  localparam int ST = (STABLE_CYCLES < 2) ? 2 : STABLE_CYCLES;
  localparam int CW = $clog2(ST + 1);
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(ST);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_e;

  logic [6:0]            seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0] com_s1_q, com_s2_q;

  state_e                         state_q;
  logic [IW-1:0]                  ref_idx_q;
  logic [6:0]                     ref_seg_q;
  logic [CW-1:0]                  cnt_q;
  logic [NUM_DIGITS-1:0][3:0]     digit_q;
  logic [NUM_DIGITS-1:0]          valid_q, err_q;
  logic                           update_q, cap01_q;
  logic [6:0]                     bin_value_q;
  logic                           bin_valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      com_s1_q <= '0;
      com_s2_q <= '0;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      com_s1_q <= com_in;
      com_s2_q <= com_s1_q;
    end
  end

  // A sample is legal only when exactly one common is pulled low.
  logic [3:0]    sel_num;
  logic [IW-1:0] sel_idx;
  logic          sel_legal, same_ref;

  always_comb begin
    sel_num = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!com_s2_q[i]) begin
        sel_num = sel_num + 1'b1;
        sel_idx = IW'(i);
      end
    end
    sel_legal = (sel_num == 4'd1);
    same_ref  = (sel_idx == ref_idx_q) && (seg_s2_q == ref_seg_q);
  end

  logic [3:0] dec_val;
  logic       dec_hit, dec_blank;

  always_comb begin
    dec_val   = '0;
    dec_hit   = 1'b1;
    dec_blank = 1'b0;
    case (ref_seg_q)
      7'b0111111: dec_val = 4'd0;
      7'b0000110: dec_val = 4'd1;
      7'b1011011: dec_val = 4'd2;
      7'b1001111: dec_val = 4'd3;
      7'b1100110: dec_val = 4'd4;
      7'b1101101: dec_val = 4'd5;
      7'b1111101: dec_val = 4'd6;
      7'b0000111: dec_val = 4'd7;
      7'b1111111: dec_val = 4'd8;
      7'b1101111: dec_val = 4'd9;
`ifdef SEG_HEX_EN
      7'b1110111: dec_val = 4'd10;
      7'b1111100: dec_val = 4'd11;
      7'b0111001: dec_val = 4'd12;
      7'b1011110: dec_val = 4'd13;
      7'b1111001: dec_val = 4'd14;
      7'b1110001: dec_val = 4'd15;
`endif
      7'b0000000: begin
        dec_hit   = 1'b0;
        dec_blank = 1'b1;
      end
      default:    dec_hit = 1'b0;
    endcase
  end

  logic       bin_ok;
  logic [6:0] bin_sum;

  always_comb begin
    bin_ok  = valid_q[0] & valid_q[1] & (digit_q[0] <= 4'd9) & (digit_q[1] <= 4'd9);
    bin_sum = {3'b000, digit_q[0]} * 7'd10 + {3'b000, digit_q[1]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ref_idx_q   <= '0;
      ref_seg_q   <= '0;
      cnt_q       <= '0;
      digit_q     <= '0;
      valid_q     <= '0;
      err_q       <= '0;
      update_q    <= 1'b0;
      cap01_q     <= 1'b0;
      bin_value_q <= '0;
      bin_valid_q <= 1'b0;
    end else begin
      update_q <= 1'b0;
      cap01_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_legal) begin
            ref_idx_q <= sel_idx;
            ref_seg_q <= seg_s2_q;
            cnt_q     <= CW'(1);
            state_q   <= TRACK;
          end
        end
        TRACK: begin
          if (!sel_legal) begin
            state_q <= IDLE;
          end else if (!same_ref) begin
            ref_idx_q <= sel_idx;
            ref_seg_q <= seg_s2_q;
            cnt_q     <= CW'(1);
          end else if (cnt_q >= CNT_MAX - 1'b1) begin
            // The sample that completes the run is also the capture cycle.
            cnt_q    <= CNT_MAX;
            state_q  <= HELD;
            update_q <= 1'b1;
            cap01_q  <= (ref_idx_q <= IW'(1));
            if (dec_hit) begin
              digit_q[ref_idx_q] <= dec_val;
              valid_q[ref_idx_q] <= 1'b1;
              err_q[ref_idx_q]   <= 1'b0;
            end else if (dec_blank) begin
              digit_q[ref_idx_q] <= 4'd0;
              valid_q[ref_idx_q] <= 1'b0;
              err_q[ref_idx_q]   <= 1'b0;
            end else begin
              valid_q[ref_idx_q] <= 1'b0;
              err_q[ref_idx_q]   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!sel_legal) begin
            state_q <= IDLE;
          end else if (!same_ref) begin
            ref_idx_q <= sel_idx;
            ref_seg_q <= seg_s2_q;
            cnt_q     <= CW'(1);
            state_q   <= TRACK;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (cap01_q) begin
        bin_valid_q <= bin_ok;
        if (bin_ok) bin_value_q <= bin_sum;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_out
      assign digit_out[4*gi +: 4] = digit_q[gi];
    end
  endgenerate

  assign digit_valid = valid_q;
  assign digit_err   = err_q;
  assign bin_value   = bin_value_q;
  assign bin_valid   = bin_valid_q;
  assign update      = update_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: directed dwells push expected captures, a monitor checks each update pulse.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  seg_in;
  logic [7:0]  com_in;
  logic [31:0] digit_out;
  logic [7:0]  digit_valid;
  logic [7:0]  digit_err;
  logic [6:0]  bin_value;
  logic        bin_valid;
  logic        update;

  seg_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
    .clock       (clk),
    .reset_n     (reset_n),
    .seg_in      (seg_in),
    .com_in      (com_in),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .digit_err   (digit_err),
    .bin_value   (bin_value),
    .bin_valid   (bin_valid),
    .update      (update)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         idx;
    logic [3:0] val;
    logic       vld;
    logic       err;
    logic [6:0] bval;
    logic       bvld;
    int         start;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   n_updates = 0;

  localparam int LATENCY = 6;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic dwell(input logic [7:0] com, input logic [6:0] seg, input int n,
                       input bit cap, input int idx, input logic [3:0] val,
                       input logic vld, input logic err, input logic [6:0] bval, input logic bvld);
    exp_t e;
    @(negedge clk);
    com_in = com;
    seg_in = seg;
    if (cap) begin
      e.idx = idx; e.val = val; e.vld = vld; e.err = err;
      e.bval = bval; e.bvld = bvld; e.start = cyc;
      sb.push_back(e);
    end
    repeat (n) @(posedge clk);
  endtask

  // Monitor: every update pulse must match the oldest expected capture.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && update) begin
        n_updates++;
        if (sb.size() == 0) begin
          chk("unexpected_update", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("digit%0d_out", e.idx), 32'(digit_out[e.idx*4 +: 4]), 32'(e.val));
          chk($sformatf("digit%0d_valid", e.idx), 32'(digit_valid[e.idx]), 32'(e.vld));
          chk($sformatf("digit%0d_err", e.idx), 32'(digit_err[e.idx]), 32'(e.err));
          chk("capture_latency", 32'(cyc - e.start), 32'(LATENCY));
          @(negedge clk);
          chk("bin_value", 32'(bin_value), 32'(e.bval));
          chk("bin_valid", 32'(bin_valid), 32'(e.bvld));
        end
      end
    end
  end

  initial begin
    int u0;
    reset_n = 1'b0;
    com_in  = 8'hFF;
    seg_in  = 7'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_digit_out", digit_out, 32'd0);
    chk("rst_digit_valid", 32'(digit_valid), 32'd0);
    chk("rst_digit_err", 32'(digit_err), 32'd0);
    chk("rst_bin_value", 32'(bin_value), 32'd0);
    chk("rst_bin_valid", 32'(bin_valid), 32'd0);
    chk("rst_update", 32'(update), 32'd0);

    u0 = n_updates;
    dwell(8'hFF, 7'b0, 50, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_no_update", 32'(n_updates - u0), 32'd0);

    // Alternating tens/ones dwells: 1 then 5 -> 15.
    dwell(~8'h01, 7'b0000110, 8, 1, 0, 4'd1, 1, 0, 7'd0,  0);
    dwell(~8'h02, 7'b1101101, 8, 1, 1, 4'd5, 1, 0, 7'd15, 1);
    dwell(~8'h01, 7'b0000110, 8, 1, 0, 4'd1, 1, 0, 7'd15, 1);
    dwell(~8'h02, 7'b1101101, 8, 1, 1, 4'd5, 1, 0, 7'd15, 1);

    // Too-short dwell: no capture.
    dwell(~8'h01, 7'b1111111, 3, 0, 0, 0, 0, 0, 0, 0);
    dwell(8'hFF, 7'b0, 8, 0, 0, 0, 0, 0, 0, 0);
    chk("short_dwell_digit0", 32'(digit_out[3:0]), 32'd1);
    chk("short_dwell_valid0", 32'(digit_valid[0]), 32'd1);

    // Unrecognised pattern keeps the old value on digit 2.
    dwell(~8'h04, 7'b0000111, 8, 1, 2, 4'd7, 1, 0, 7'd15, 1);
    dwell(~8'h04, 7'b1001001, 6, 1, 2, 4'd7, 0, 1, 7'd15, 1);
    dwell(8'hFF, 7'b0, 4, 0, 0, 0, 0, 0, 0, 0);
    chk("err_other_digits", 32'(digit_valid[1:0]), 32'd3);

    // Blank after 8 on digit 3 clears it.
    dwell(~8'h08, 7'b1111111, 8, 1, 3, 4'd8, 1, 0, 7'd15, 1);
    dwell(~8'h08, 7'b0000000, 6, 1, 3, 4'd0, 0, 0, 7'd15, 1);
    dwell(8'hFF, 7'b0, 4, 0, 0, 0, 0, 0, 0, 0);

    // Two commons low: no selection.
    u0 = n_updates;
    dwell(~8'h03, 7'b0000110, 10, 0, 0, 0, 0, 0, 0, 0);
    chk("multi_com_no_update", 32'(n_updates - u0), 32'd0);

    // Reset in the middle of a TRACK dwell.
    dwell(~8'h01, 7'b1111111, 4, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_digit_out", digit_out, 32'd0);
    chk("midrst_digit_valid", 32'(digit_valid), 32'd0);
    chk("midrst_digit_err", 32'(digit_err), 32'd0);
    chk("midrst_bin_value", 32'(bin_value), 32'd0);
    chk("midrst_bin_valid", 32'(bin_valid), 32'd0);
    com_in = 8'hFF;
    seg_in = 7'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    u0 = n_updates;
    dwell(8'hFF, 7'b0, 8, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_no_update", 32'(n_updates - u0), 32'd0);

    // 3 then 1 -> 31, then hex A on the ones digit.
    dwell(~8'h01, 7'b1001111, 8, 1, 0, 4'd3, 1, 0, 7'd0,  0);
    dwell(~8'h02, 7'b0000110, 8, 1, 1, 4'd1, 1, 0, 7'd31, 1);
`ifdef SEG_HEX_EN
    dwell(~8'h02, 7'b1110111, 8, 1, 1, 4'd10, 1, 0, 7'd31, 0);
`else
    dwell(~8'h02, 7'b1110111, 8, 1, 1, 4'd1, 0, 1, 7'd31, 0);
`endif
    dwell(8'hFF, 7'b0, 10, 0, 0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
